// File: rtl/conv_encoder_frame_if.sv
// Frame/symbol interface of the rate-1/2 K=3 convolutional encoder.
// The encoder connects through master; the source/sink side connects through slave.
interface conv_encoder_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 st;
  logic [DATA_BITS-1:0] data_in;
  logic                 code_ready;
  logic [1:0]           code_out;
  logic                 code_valid;
  logic                 busy;
  logic                 done;
  logic                 is_tail;
  logic [1:0]           state_test;

  modport master (
    input  st, data_in, code_ready,
    output code_out, code_valid, busy, done, is_tail, state_test
  );

  modport slave (
    output st, data_in, code_ready,
    input  code_out, code_valid, busy, done, is_tail, state_test
  );
endinterface

// File: rtl/conv_encoder_frame.sv
// Rate-1/2, K=3 convolutional encoder: serialises one frame MSB-first,
// then appends two zero tail symbols so the trellis ends in state 0.
module conv_encoder_frame #(
  parameter int         DATA_BITS = 8,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input logic                 clk,
  input logic                 rst,
  conv_encoder_frame_if.master enc
);
  localparam int CW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_TAIL = CW'(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, ENCODE, FLUSH, FINISH} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_sr;
  logic [DATA_BITS-1:0] r_buf;
  logic [CW-1:0]        r_cnt;
  logic                 w_valid;
  logic                 w_accept;
  logic                 w_u;
  logic [2:0]           w_taps;
  logic [1:0]           w_sym;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_u     = 1'b0;
    unique case (r_state)
      IDLE:   if (enc.st) w_next = ENCODE;
      ENCODE: begin
        w_valid = 1'b1;
        w_u     = r_buf[DATA_BITS-1];
        if (enc.code_ready && r_cnt == LAST_DATA) w_next = FLUSH;
      end
      FLUSH: begin
        w_valid = 1'b1;
        if (enc.code_ready && r_cnt == LAST_TAIL) w_next = FINISH;
      end
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = w_valid & enc.code_ready;
  assign w_taps   = {w_u, r_sr};
  assign w_sym    = {^(w_taps & G0), ^(w_taps & G1)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_buf <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE && enc.st) begin
      r_sr  <= '0;
      r_buf <= enc.data_in;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sr  <= {w_u, r_sr[1]};
      r_buf <= r_buf << 1;
      // parked at zero on the final tail so the counter never wraps
      r_cnt <= (r_state == FLUSH && r_cnt == LAST_TAIL) ? '0 : r_cnt + 1'b1;
    end
  end

  assign enc.code_out   = w_valid ? w_sym : 2'b00;
  assign enc.code_valid = w_valid;
  assign enc.busy       = (r_state != IDLE);
  assign enc.done       = (r_state == FINISH);
  assign enc.is_tail    = (r_state == FLUSH);
  assign enc.state_test = r_sr;
endmodule
